// File: rtl/serial_bit_source_if.sv
// Handshake/data bundle between a word producer and the serial bit source.
interface serial_bit_source_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             Start;
  logic             Stop;
  logic             Repeat;
  logic [WIDTH-1:0] Data;
  logic             Out;
  logic             Bit_tick;
  logic             Busy;
  logic             Done;
  logic [CW-1:0]    Bit_cnt;

  modport master (
    output Start, Stop, Repeat, Data,
    input  Out, Bit_tick, Busy, Done, Bit_cnt
  );

  modport slave (
    input  Start, Stop, Repeat, Data,
    output Out, Bit_tick, Busy, Done, Bit_cnt
  );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source: captures a word on Start and shifts it out MSB-first,
// holding each bit for DIV clocks, with repeat, abort and per-bit strobe.
module serial_bit_source #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic               clk,
  input  logic               Reset_n,
  serial_bit_source_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, word_q, word_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d, tick_q, tick_d, busy_q, busy_d, done_q, done_d;

  logic presc_last, cnt_last, accept;
  assign presc_last = (presc_q == PW'(DIV - 1));
  assign cnt_last   = (cnt_q == CW'(WIDTH - 1));
  // Stop beats Start when both arrive together in IDLE
  assign accept     = bus.Start && !bus.Stop;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      word_q  <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      word_q  <= word_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: begin
        if (bus.Stop)                                    state_d = S_IDLE;
        else if (presc_last && cnt_last && !bus.Repeat)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    sreg_d  = sreg_q;
    word_d  = word_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    tick_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sreg_d  = bus.Data;
          word_d  = bus.Data;
          presc_d = '0;
          cnt_d   = '0;
          out_d   = bus.Data[WIDTH-1];
          tick_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bus.Stop) begin
          presc_d = '0;
          cnt_d   = '0;
        end else if (presc_last) begin
          presc_d = '0;
          if (!cnt_last) begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q + CW'(1);
            out_d  = sreg_q[WIDTH-2];
            tick_d = 1'b1;
            busy_d = 1'b1;
          end else if (bus.Repeat) begin
            // Replay the captured copy; live Data is not looked at again
            sreg_d = word_q;
            cnt_d  = '0;
            out_d  = word_q[WIDTH-1];
            tick_d = 1'b1;
            busy_d = 1'b1;
          end else begin
            cnt_d  = '0;
            done_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          out_d   = out_q;
          busy_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.Out      = out_q;
  assign bus.Bit_tick = tick_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Bit_cnt  = cnt_q;
endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
Parallel-to-serial stimulus source that sits directly upstream of the lab's serial Mealy sequence FSMs. It drives their single-bit input.
- Captures a WIDTH-bit word on Start and shifts it out MSB-first.
- Holds each bit for DIV clocks.
- Provides a per-bit strobe, busy/done status, an optional continuous repeat mode and an abort.

Parameters:
WIDTH, 8, bits per word; legal values >= 2.
DIV, 1, clocks each bit is held on Out; legal values >= 1. DIV=1 gives one bit per clock, for feeding an FSM clocked every cycle.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  request to capture Data and begin shifting; honoured only in IDLE.
Stop  input  1  abort the current word immediately.
Repeat  input  1  when 1 at a word boundary, restart the same word with no gap.
Data  input  WIDTH  word to serialise; sampled only on an accepted Start.
Out  output  1  serial bit to the downstream FSM input, registered.
Bit_tick  output  1  one-clock strobe on the first cycle of each bit period.
Busy  output  1  high while in SHIFT.
Done  output  1  one-clock pulse after a word completes without abort.
Bit_cnt  output  ceil(log2(WIDTH))  index of the bit currently on Out; 0 = MSB.

Behaviour:
- Reset (Reset_n low, asynchronous, any state): state=IDLE; Out, Bit_tick, Busy, Done, Bit_cnt, shift register, word copy and prescaler all 0.
- State machine: states IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - Out=0, Busy=0.
  - Start=1 and Stop=0 at edge t: capture Data into both the shift register and the word copy; clear prescaler and Bit_cnt; go to SHIFT.
  - After edge t: Out=Data[WIDTH-1], Busy=1, Bit_tick=1.
  - Start=1 and Stop=1 in the same cycle: Stop wins; remain in IDLE.
- SHIFT:
  - Bit i is on Out for cycles t+1+i*DIV through t+(i+1)*DIV.
  - Bit_tick=1 only in the first of those cycles.
  - Prescaler counts 0..DIV-1. At DIV-1:
    - if Bit_cnt < WIDTH-1: shift left, Bit_cnt+1, prescaler=0.
    - if Bit_cnt = WIDTH-1 and Repeat=1: reload the shift register from the word copy (not from Data), Bit_cnt=0, Bit_tick=1 next cycle, no idle gap, no Done.
    - if Bit_cnt = WIDTH-1 and Repeat=0: go to DONE.
  - Start while in SHIFT: ignored; Data changes have no effect.
  - Stop=1 at any edge: go to IDLE. Next cycle Out=0, Busy=0, Bit_tick=0, Bit_cnt=0, no Done pulse.
- DONE:
  - Occupies exactly one cycle: Done=1, Busy=0, Out=0, Bit_tick=0.
  - Then unconditionally IDLE. Start during the DONE cycle is ignored.
- Non-repeating word: Start edge to Done high = WIDTH*DIV+1 clocks. Busy is high for WIDTH*DIV cycles.
- Repeat is sampled only at the last-bit boundary. Deasserting it mid-word finishes that word, then gives one Done.
- Reset mid-operation: immediate return to reset values; no Done; the word copy is lost.

Test Plan:
1. WIDTH=8, DIV=1, Data=8'b1011_0010, 1-cycle Start -> Out=1,0,1,1,0,0,1,0 on 8 consecutive cycles; Bit_cnt 0..7; Busy high 8 cycles; Done=1 on cycle 9; Bit_tick high all 8 cycles.
2. DIV=4, Data=8'hC3 -> each bit held 4 cycles; 8 Bit_tick pulses spaced 4 apart; Done 33 cycles after the Start edge.
3. DIV=1, Repeat=1, Data=8'hA5, change Data to 8'hFF after Start -> Out streams A5 A5 A5 MSB-first with no gap; drop Repeat mid-word -> the current A5 completes, then a single Done.
4. Start with Data=8'h0F, then Start with 8'hF0 during bit 3 -> ignored; output remains 0F. Start+Stop together in IDLE -> Busy stays 0.
5. Stop asserted during bit 5 -> next cycle Out=0, Busy=0, Bit_cnt=0; Done never pulses.
6. Reset_n low during bit 2 of a DIV=4 word -> all outputs 0 before the next clk edge. After release, a new Start produces a clean full word.
